// File: rtl/ans_pkg.sv
// Shared widths, command encodings and FSM states
// for the ANS table controller slice.
package ans_pkg;

   localparam int SYM_WIDTH = 4;
   localparam int CNT_WIDTH = 4;
   localparam int TOT_WIDTH = CNT_WIDTH + SYM_WIDTH;
   localparam int SYM_COUNT = 2 ** SYM_WIDTH;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_ENC  = 2'b01,
      CMD_DEC  = 2'b10,
      CMD_LOAD = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SCAN,
      ST_RUN
   } state_e;

endpackage

// File: rtl/ans_prefix_scan.sv
// Frequency table storage with a one-entry-per-cycle
// prefix-sum scan and a combinational lookup port.
module ans_prefix_scan
   import ans_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [SYM_WIDTH-1:0] wr_idx,
   input  logic [CNT_WIDTH-1:0] wr_cnt,
   input  logic                 scan_en,
   input  logic [SYM_WIDTH-1:0] lk_sym,
   output logic [CNT_WIDTH-1:0] lk_count,
   output logic [TOT_WIDTH-1:0] lk_cum,
   output logic [TOT_WIDTH-1:0] total,
   output logic [TOT_WIDTH-1:0] acc_next,
   output logic                 scan_last
);

   logic [CNT_WIDTH-1:0] counts [SYM_COUNT];
   logic [TOT_WIDTH-1:0] cum    [SYM_COUNT];
   logic [TOT_WIDTH-1:0] acc;
   logic [SYM_WIDTH-1:0] cnt;

   assign acc_next  = acc + TOT_WIDTH'(counts[cnt]);
   assign scan_last = scan_en && (&cnt);
   assign lk_count  = counts[lk_sym];
   assign lk_cum    = cum[lk_sym];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYM_COUNT; i++) begin
            counts[i] <= '0;
            cum[i]    <= '0;
         end
         acc   <= '0;
         cnt   <= '0;
         total <= '0;
      end else begin
         if (wr_en)
            counts[wr_idx] <= wr_cnt;
         if (scan_en) begin
            cum[cnt] <= acc;
            cnt      <= cnt + 1'b1;
            // acc is rearmed so the next scan starts from zero
            if (scan_last) begin
               acc   <= '0;
               total <= acc_next;
            end else begin
               acc <= acc_next;
            end
         end
      end
   end

endmodule

// File: rtl/ans_table_ctrl.sv
// Mode FSM and handshake gating in front of the ANS encoder;
// owns table load, scan sequencing and table validity.
module ans_table_ctrl
   import ans_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           cmd,
   input  logic [SYM_WIDTH-1:0] in,
   input  logic                 in_vld,
   output logic                 in_rdy,
   output logic [SYM_WIDTH-1:0] enc_sym,
   output logic [CNT_WIDTH-1:0] enc_s_count,
   output logic [TOT_WIDTH-1:0] enc_s_cumulative,
   output logic [TOT_WIDTH-1:0] enc_total,
   output logic                 enc_in_vld,
   input  logic                 enc_in_rdy,
   output logic                 table_vld,
   output logic                 busy,
   output logic                 err
);

   state_e               state;
   state_e               state_n;
   logic [SYM_WIDTH-1:0] idx;
   logic                 ld_wr;
   logic                 scan_en;
   logic                 scan_last;
   logic                 nz;
   logic [CNT_WIDTH-1:0] lk_count;
   logic [TOT_WIDTH-1:0] lk_cum;
   logic [TOT_WIDTH-1:0] total;
   logic [TOT_WIDTH-1:0] acc_next;

   ans_prefix_scan u_scan (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ld_wr),
      .wr_idx    (idx),
      .wr_cnt    (in[CNT_WIDTH-1:0]),
      .scan_en   (scan_en),
      .lk_sym    (in),
      .lk_count  (lk_count),
      .lk_cum    (lk_cum),
      .total     (total),
      .acc_next  (acc_next),
      .scan_last (scan_last)
   );

   assign nz   = (lk_count != '0);
   assign busy = (state == ST_LOAD) || (state == ST_SCAN);

   always_comb begin
      state_n          = state;
      in_rdy           = 1'b0;
      enc_in_vld       = 1'b0;
      enc_sym          = '0;
      enc_s_count      = '0;
      enc_s_cumulative = '0;
      enc_total        = '0;
      ld_wr            = 1'b0;
      scan_en          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd == CMD_LOAD)
               state_n = ST_LOAD;
            else if (cmd == CMD_ENC && table_vld)
               state_n = ST_RUN;
         end
         ST_LOAD: begin
            in_rdy = 1'b1;
            // leaving LOAD swallows any beat offered that cycle
            if (cmd != CMD_LOAD) begin
               state_n = ST_IDLE;
            end else if (in_vld) begin
               ld_wr = 1'b1;
               if (&idx)
                  state_n = ST_SCAN;
            end
         end
         ST_SCAN: begin
            scan_en = 1'b1;
            if (scan_last)
               state_n = ST_IDLE;
         end
         ST_RUN: begin
            enc_sym          = in;
            enc_s_count      = lk_count;
            enc_s_cumulative = lk_cum;
            enc_total        = total;
            enc_in_vld       = in_vld && nz;
            // zero-count symbols are drained without the encoder
            in_rdy           = nz ? enc_in_rdy : 1'b1;
            if (cmd != CMD_ENC)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         table_vld <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && cmd == CMD_LOAD) begin
            idx       <= '0;
            table_vld <= 1'b0;
            err       <= 1'b0;
         end
         if (state == ST_IDLE && cmd == CMD_ENC && !table_vld)
            err <= 1'b1;
         if (ld_wr)
            idx <= idx + 1'b1;
         if (scan_last) begin
            if (acc_next == '0)
               err <= 1'b1;
            else
               table_vld <= 1'b1;
         end
         if (state == ST_RUN && in_vld && !nz)
            err <= 1'b1;
      end
   end

endmodule

// File: doc/ans_table_ctrl.md
Name: ans_table_ctrl

Overview:
- Controller and configurer placed in front of the ANS encoder datapath.
- Sequences a frequency-table load of 16 symbol counts, then a prefix-sum scan that builds the cumulative table and total count.
- In encode mode, gates the symbol stream into the encoder and supplies each symbol's s_count, s_cumulative and total_count.
- Owns the mode decode (cmd) so the encoder never receives symbols against a stale or partial table.

Parameters:
- SYM_WIDTH, 4, symbol width; table depth SYM_COUNT = 2**SYM_WIDTH.
- CNT_WIDTH, 4, per-symbol count width.
- TOT_WIDTH, CNT_WIDTH+SYM_WIDTH (8), cumulative and total width; holds the worst case 15*16=240 without overflow.

Ports:
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset, sampled on the clk rising edge.
- cmd  in  2  00 idle, 01 encode, 10 decode (reserved, treated as idle), 11 load.
- in  in  SYM_WIDTH  count nibble in LOAD; symbol in RUN.
- in_vld  in  1  upstream valid.
- in_rdy  out  1  upstream ready.
- enc_sym  out  SYM_WIDTH  symbol forwarded to the encoder; equals in.
- enc_s_count  out  CNT_WIDTH  counts[in].
- enc_s_cumulative  out  TOT_WIDTH  cum[in].
- enc_total  out  TOT_WIDTH  registered total of all counts.
- enc_in_vld  out  1  valid to the encoder.
- enc_in_rdy  in  1  ready from the encoder.
- table_vld  out  1  table complete and total nonzero.
- busy  out  1  high in LOAD or SCAN.
- err  out  1  sticky error flag; cleared only by rst or by entering LOAD.

Behaviour:
- Reset values: state IDLE, idx=0, all counts/cum=0, total=0, table_vld=0, err=0, in_rdy=0, enc_in_vld=0, busy=0.
- FSM states: IDLE, LOAD, SCAN, RUN. A transfer occurs only when valid and ready are both high on a clk edge.
- IDLE:
  - cmd=11 → LOAD next cycle; clear table_vld, err and idx.
  - cmd=01 with table_vld=1 → RUN.
  - cmd=01 with table_vld=0 → stay in IDLE and set err.
  - Otherwise stay in IDLE. in_rdy=0.
- LOAD:
  - in_rdy=1. Each transfer writes counts[idx]=in and increments idx.
  - The transfer at idx=15 → SCAN with idx wrapping to 0.
  - cmd≠11 while in LOAD → IDLE next cycle. The partial table is discarded and table_vld stays 0. A transfer in that same cycle is ignored.
- SCAN:
  - in_rdy=0; runs exactly 16 cycles and ignores cmd.
  - Cycle k writes cum[k]=acc, then acc+=counts[k]; acc starts at 0.
  - After k=15: total=acc, then → IDLE.
  - If total≠0, table_vld=1; if total=0, set err and leave table_vld=0.
  - Load-to-table_vld latency is 16 transfers + 16 cycles + 1.
- RUN:
  - enc_in_vld = in_vld & (counts[in]≠0).
  - in_rdy = enc_in_rdy when counts[in]≠0, else 1.
  - A zero-count symbol is consumed and dropped, and sets err.
  - Lookups are combinational from the registered table (zero latency). enc_total=total.
  - cmd≠01 → IDLE next cycle. A transfer in the exit cycle completes normally.
- Outside RUN: enc_in_vld=0 and the enc_* data outputs are don't-care (drive 0).
- decode (10): no action, stays IDLE; reserved for a future decoder controller.
- rst mid-LOAD/SCAN/RUN: immediate return to reset values on the next edge; the table is invalid.

Decomposition:
- Shared package ans_pkg:
  - SYM_WIDTH, CNT_WIDTH, TOT_WIDTH, SYM_COUNT.
  - cmd encodings CMD_IDLE/CMD_ENC/CMD_DEC/CMD_LOAD.
  - FSM state enum.
- One natural sub-module: ans_prefix_scan. It holds the count array, the cumulative array, the accumulator and the scan counter, and provides a combinational lookup port.
- The FSM and handshake gating stay in ans_table_ctrl.

Test Plan:
- Load counts 1..15,1 (sym0=1 … sym14=15, sym15=1) → after 16 transfers plus 16 scan cycles: table_vld=1, total=121, cum[0]=0, cum[1]=1, cum[3]=6, cum[15]=120, busy low.
- After that load, cmd=01 and symbols 3,0,15 with enc_in_rdy stalled one cycle on symbol 0 → enc outputs (4,6),(1,0),(1,120) with enc_total=121. Symbol 0 is held until enc_in_rdy; there is no loss or duplication.
- Load all-zero counts → err=1, table_vld=0. A following cmd=01 stays IDLE with in_rdy=0.
- Load with counts[5]=0, then encode symbol 5 → in_rdy=1, enc_in_vld=0, err=1. The next symbol 2 passes normally.
- Switch cmd to 00 after 7 load transfers → IDLE next cycle with table_vld=0. A fresh full load then succeeds with idx restarted at 0.
- Assert rst during SCAN cycle 8 → all outputs at reset values the next cycle. cmd=01 then sets err because table_vld=0.
